i2c_passthru_bitsched: RTL
==========================

Name: i2c_passthru_bitsched

Overview:
- Bit-level scheduler for the passthru SDA/SCL transmit bit engine.
- Tracks I2C framing (START, address byte, R/W, data bytes, ACK slots) and decides per bit whether the bit engine transmits toward the master or toward the slave.
- Issues start-of-bit requests, supervises completion with a timeout, and halts on engine violations.
- Sits between the bus receive/monitor logic and the bit engine.

Parameters:
- F_REF_T_TIMEOUT, 255, max i_f_ref rising edges allowed between start_tx and tx_done (minimum 2).
- WIDTH_F_REF_T_TIMEOUT, 8, CEILING(LOG2(F_REF_T_TIMEOUT+1)).
- WIDTH_BYTE_CNT, 8, width of the saturating byte counter.

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  synchronous reset, active low
- i_f_ref  input  1  timing reference; rising edges count
- i_start_cond  input  1  one-cycle pulse: START or repeated START detected
- i_stop_cond  input  1  one-cycle pulse: STOP detected
- i_bit_begin  input  1  one-cycle pulse: master pulled SCL low, new bit slot begun
- i_rx_sda_final  input  1  final SDA value of the completed bit
- i_tx_done  input  1  bit engine idle / bit complete (level)
- i_violation  input  1  bit engine violation (level)
- i_slv_on_mst_ch  input  1  slave drove the master channel (pulse or level)
- o_start_tx  output  1  one-cycle request to the bit engine
- o_tx_is_to_mst  output  1  direction of the current/next bit (1 = slave to master)
- o_bit_idx  output  4  bit index within byte, 0..8 (8 = ACK)
- o_byte_cnt  output  WIDTH_BYTE_CNT  bytes completed since START, saturating
- o_rw  output  1  R/W bit latched from the address byte
- o_nack  output  1  last ACK slot sampled 1
- o_timeout  output  1  sticky; timeout occurred
- o_halt  output  1  scheduler halted (violation or timeout)
- o_data  output  8  last completed byte, MSB first

Behaviour:
- Reset: all outputs 0, state ST_IDLE, pending flag 0.
- States: ST_IDLE, ST_ARMED, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_ADVANCE, ST_HALT.
- ST_IDLE -> ST_ARMED on i_start_cond. Entering ST_ARMED clears bit_idx, byte_cnt, o_rw, o_nack, shift register.
- Pending flag: set by i_bit_begin in any non-idle, non-halt state; cleared when o_start_tx fires.
- ST_ARMED -> ST_ISSUE when pending=1 and i_tx_done=1.
- ST_ISSUE: o_start_tx=1 for exactly one cycle; reset timeout counter; go to ST_WAIT_BUSY.
- ST_WAIT_BUSY: wait for i_tx_done=0, then ST_WAIT_DONE. Limit is 2 cycles; if still high, go to ST_HALT and set o_timeout.
- ST_WAIT_DONE: on i_tx_done=1, go to ST_ADVANCE. Decrement the timeout counter on each f_ref rising edge; at 0, set o_timeout and go to ST_HALT.
- ST_ADVANCE (1 cycle):
  - bit_idx<8: shift i_rx_sda_final into o_data LSB. If byte_cnt=0 and bit_idx=7, latch o_rw=i_rx_sda_final.
  - bit_idx=8: o_nack=i_rx_sda_final; byte_cnt+1, saturating at all-ones; bit_idx wraps to 0.
  - Otherwise bit_idx+1. Return to ST_ARMED.
- Read with o_nack=1 at the ACK slot: go to ST_IDLE (master ends transfer; await STOP or repeated START).
- Direction o_tx_is_to_mst, combinational from bit_idx/byte_cnt/o_rw:
  - byte 0: bits 0-7 -> 0; bit 8 -> 1.
  - write: bits 0-7 -> 0; bit 8 -> 1.
  - read: bits 0-7 -> 1; bit 8 -> 0.
- i_violation=1 in any state except ST_IDLE -> ST_HALT next cycle.
- ST_HALT: o_halt=1; exits only via i_stop_cond (-> ST_IDLE) or reset.
- i_stop_cond in ST_ARMED/ST_ISSUE/ST_WAIT_*/ST_ADVANCE -> ST_IDLE; pending cleared.
- i_start_cond in any non-halt state -> ST_ARMED with counters cleared. Same-cycle start+stop: start wins.
- i_bit_begin same cycle as o_start_tx: sets pending again (pending for the next bit).
- i_slv_on_mst_ch: no state effect; the bit completes normally.
- Reset mid-bit: outputs return to reset values next cycle; no o_start_tx.

Decomposition:
- Shared package i2c_passthru_pkg:
  - state localparams
  - ACK_BIT_IDX=8
  - DIR_TO_MST=1, DIR_TO_SLV=0
  - BUSY_WAIT_MAX=2
- Sub-module i2c_passthru_ref_timer: loadable down-counter on i_f_ref rising edges with terminal-count output; reusable by the other passthru blocks.

Test Plan:
- START; address 0xA0, ACK 0; data 0x55, ACK 0; STOP -> 18 o_start_tx pulses; o_rw=0; o_tx_is_to_mst=1 only at bit_idx 8; byte_cnt=2; o_data=0x55; return to ST_IDLE.
- START; 0xA1, ACK 0; read 0x3C, master ACK 0; read 0xFF, master ACK 1 -> o_rw=1; data bits o_tx_is_to_mst=1, ACK bits 0; o_nack=1; ST_IDLE after the third ACK; no further start_tx on later i_bit_begin.
- Assert i_violation during bit 3 of the address byte -> o_halt=1 next cycle; i_bit_begin ignored; i_stop_cond -> ST_IDLE, o_halt=0.
- Hold i_tx_done=0 for 256 f_ref edges after start_tx (F_REF_T_TIMEOUT=255) -> o_timeout=1 at edge 255; o_halt=1.
- Repeated START at bit 5 of data byte 1 -> bit_idx=0, byte_cnt=0, o_rw cleared; next address byte scheduled normally.
- Drop i_rstn during ST_WAIT_DONE; hold i_bit_begin=1 -> all outputs 0 next cycle; no o_start_tx until a new i_start_cond.

Source files
------------

// File: rtl/i2c_passthru_pkg.sv
// Shared types and constants for the I2C passthru blocks.
package i2c_passthru_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_ADVANCE,
    ST_HALT
  } state_e;

  localparam logic [3:0] ACK_BIT_IDX = 4'd8;
  localparam logic DIR_TO_MST = 1'b1;
  localparam logic DIR_TO_SLV = 1'b0;
  localparam int unsigned BUSY_WAIT_MAX = 2;

  // Address byte and write data: master drives data, slave drives ACK. Read data inverts that.
  function automatic logic tx_dir(logic [3:0] bit_idx, logic first_byte, logic rw);
    logic is_ack;
    is_ack = (bit_idx == ACK_BIT_IDX);
    if (first_byte || !rw) return is_ack ? DIR_TO_MST : DIR_TO_SLV;
    return is_ack ? DIR_TO_SLV : DIR_TO_MST;
  endfunction

endpackage

// File: rtl/i2c_passthru_ref_timer.sv
// Loadable down-counter clocked by rising edges of a slow reference, with terminal-count flag.
module i2c_passthru_ref_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_f_ref,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic             f_ref_q;
  logic [WIDTH-1:0] cnt_q;
  logic             rise;

  assign rise = i_f_ref & ~f_ref_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      f_ref_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      f_ref_q <= i_f_ref;
      if (i_load) begin
        cnt_q <= i_load_val;
      end else if (i_en && rise && (cnt_q != '0)) begin
        cnt_q <= cnt_q - WIDTH'(1);
      end
    end
  end

  // Flags the edge that takes the count to zero, so the caller reacts on that same cycle.
  assign o_tc = i_en & ~i_load & ((cnt_q == '0) | (rise & (cnt_q == WIDTH'(1))));

endmodule

// File: rtl/i2c_passthru_bitsched.sv
// Per-bit scheduler: follows I2C framing, picks the transmit direction and supervises the bit engine.
module i2c_passthru_bitsched
  import i2c_passthru_pkg::*;
#(
  parameter int unsigned F_REF_T_TIMEOUT       = 255,
  parameter int unsigned WIDTH_F_REF_T_TIMEOUT = 8,
  parameter int unsigned WIDTH_BYTE_CNT        = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_f_ref,
  input  logic                      i_start_cond,
  input  logic                      i_stop_cond,
  input  logic                      i_bit_begin,
  input  logic                      i_rx_sda_final,
  input  logic                      i_tx_done,
  input  logic                      i_violation,
  input  logic                      i_slv_on_mst_ch,
  output logic                      o_start_tx,
  output logic                      o_tx_is_to_mst,
  output logic [3:0]                o_bit_idx,
  output logic [WIDTH_BYTE_CNT-1:0] o_byte_cnt,
  output logic                      o_rw,
  output logic                      o_nack,
  output logic                      o_timeout,
  output logic                      o_halt,
  output logic [7:0]                o_data
);

  state_e                    state_q, state_d;
  logic                      pending_q, pending_d;
  logic [1:0]                busy_q, busy_d;
  logic [3:0]                bit_idx_q;
  logic [WIDTH_BYTE_CNT-1:0] byte_cnt_q;
  logic                      rw_q, nack_q, timeout_q;
  logic [7:0]                data_q;
  logic                      clear, timeout_set, bit_ok, tmr_tc;
  logic                      unused_slv;

  // A slave driving the master channel is tolerated; the bit simply completes.
  assign unused_slv = i_slv_on_mst_ch;

  i2c_passthru_ref_timer #(
    .WIDTH (WIDTH_F_REF_T_TIMEOUT)
  ) u_ref_timer (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_f_ref    (i_f_ref),
    .i_load     (state_q == ST_ISSUE),
    .i_load_val (WIDTH_F_REF_T_TIMEOUT'(F_REF_T_TIMEOUT)),
    .i_en       ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE)),
    .o_tc       (tmr_tc)
  );

  assign bit_ok = i_bit_begin && (state_q != ST_IDLE) && (state_q != ST_HALT);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    clear       = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start_cond) begin
          state_d = ST_ARMED;
          clear   = 1'b1;
        end
      end
      ST_ARMED: if (pending_q && i_tx_done) state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
        busy_d  = '0;
      end
      ST_WAIT_BUSY: begin
        if (!i_tx_done) begin
          state_d = ST_WAIT_DONE;
        end else if (busy_q == 2'(BUSY_WAIT_MAX - 1)) begin
          state_d     = ST_HALT;
          timeout_set = 1'b1;
        end else begin
          busy_d = busy_q + 2'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          state_d = ST_ADVANCE;
        end else if (tmr_tc) begin
          state_d     = ST_HALT;
          timeout_set = 1'b1;
        end
      end
      ST_ADVANCE: begin
        // A master NACK on read data ends the transfer; wait for STOP or repeated START.
        if ((bit_idx_q == ACK_BIT_IDX) && rw_q && i_rx_sda_final) state_d = ST_IDLE;
        else state_d = ST_ARMED;
      end
      ST_HALT: if (i_stop_cond) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && (state_q != ST_HALT)) begin
      if (i_stop_cond) state_d = ST_IDLE;
      if (i_start_cond) begin
        state_d = ST_ARMED;
        clear   = 1'b1;
      end
    end
    if (i_violation && (state_q != ST_IDLE)) begin
      state_d = ST_HALT;
      clear   = 1'b0;
    end

    pending_d = (((state_q == ST_ISSUE) || i_start_cond) ? 1'b0 : pending_q) | bit_ok;
    if ((state_d == ST_IDLE) || (state_d == ST_HALT)) pending_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      busy_q     <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      timeout_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_q | timeout_set;
      if (clear) begin
        bit_idx_q  <= '0;
        byte_cnt_q <= '0;
        rw_q       <= 1'b0;
        nack_q     <= 1'b0;
        data_q     <= '0;
      end else if (state_q == ST_ADVANCE) begin
        if (bit_idx_q != ACK_BIT_IDX) begin
          data_q    <= {data_q[6:0], i_rx_sda_final};
          bit_idx_q <= bit_idx_q + 4'd1;
          if ((byte_cnt_q == '0) && (bit_idx_q == 4'd7)) rw_q <= i_rx_sda_final;
        end else begin
          nack_q    <= i_rx_sda_final;
          bit_idx_q <= '0;
          if (byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + WIDTH_BYTE_CNT'(1);
        end
      end
    end
  end

  assign o_start_tx     = (state_q == ST_ISSUE);
  assign o_halt         = (state_q == ST_HALT);
  assign o_tx_is_to_mst = tx_dir(bit_idx_q, byte_cnt_q == '0, rw_q);
  assign o_bit_idx      = bit_idx_q;
  assign o_byte_cnt     = byte_cnt_q;
  assign o_rw           = rw_q;
  assign o_nack         = nack_q;
  assign o_timeout      = timeout_q;
  assign o_data         = data_q;

endmodule
